edge_magnitude: RTL
===================

EDGE_MAGNITUDE -- requirements
Module: edge_magnitude

Interface
REQ-001 Parameter IMG_WIDTH, default 640: pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480: lines per frame.
REQ-003 Parameter GRAD_WIDTH, default 18: width of each unsigned gradient input.
REQ-004 Parameter DATA_WIDTH, default 12: width of the output pixel.
REQ-005 i_clk  in  1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 i_rst  in  1: reset, asynchronous and active-high.
REQ-007 i_sof  in  1: start-of-frame pulse.
REQ-008 i_gx_valid  in  1: horizontal-gradient sample valid.
REQ-009 i_gx  in  GRAD_WIDTH: horizontal gradient magnitude, unsigned.
REQ-010 i_gy_valid  in  1: vertical-gradient sample valid.
REQ-011 i_gy  in  GRAD_WIDTH: vertical gradient magnitude, unsigned.
REQ-012 i_thresh_en  in  1: binarise the output when high.
REQ-013 i_threshold  in  DATA_WIDTH: binarisation threshold.
REQ-014 o_pix_valid  out  1: output pixel valid.
REQ-015 o_pix  out  DATA_WIDTH: edge-magnitude pixel.
REQ-016 o_frame_done  out  1: one-cycle pulse when the last pixel of a frame is output.
REQ-017 o_err  out  1: sticky protocol error flag.

Function
REQ-018 FSM states SHALL be IDLE and ACTIVE.
- IDLE to ACTIVE on i_sof.
- ACTIVE to IDLE after accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-019 A pair SHALL be accepted when i_gx_valid and i_gy_valid are both high in the same cycle, and either the state is ACTIVE or i_sof is high.
REQ-020 In IDLE without i_sof, valid inputs SHALL be ignored and SHALL NOT set o_err.
REQ-021 In ACTIVE, exactly one of i_gx_valid/i_gy_valid high SHALL:
- drop the sample;
- leave the counters unchanged;
- set o_err.
REQ-022 Column counter col SHALL increment per accepted pair; wrap at IMG_WIDTH-1 to 0 and increment row counter row.
REQ-023 i_sof SHALL force col=0 and row=0 in that cycle; a pair accepted in the same cycle SHALL be pixel (0,0), and the counters SHALL then advance to (1,0).
REQ-024 i_sof while ACTIVE and not on the last pixel SHALL set o_err and restart the frame.
REQ-025 Stage 1: sum = i_gx + i_gy, GRAD_WIDTH+1 bits, no overflow; col/row/last flags registered alongside.
REQ-026 Stage 2: sat = min(sum, 2^DATA_WIDTH-1).
- If i_thresh_en: o_pix = (sat >= i_threshold) ? all-ones : 0.
- Otherwise: o_pix = sat.
REQ-027 Border pixels (col<2 or row<2, the 3x3 window warm-up region) SHALL output o_pix=0 with o_pix_valid=1.
REQ-028 Latency: accepted pair in cycle N SHALL produce o_pix_valid=1 in cycle N+2; one output per accepted pair, in order, no bubbles added.
REQ-029 i_threshold and i_thresh_en SHALL be sampled in stage 2.
REQ-030 o_frame_done SHALL pulse with o_pix_valid on the output of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-031 The pipeline SHALL flow every cycle with no backpressure; an in-flight sample SHALL complete even if i_sof arrives.

Reset
REQ-032 i_rst SHALL asynchronously force:
- state=IDLE, col=0, row=0;
- all pipeline valid bits=0;
- o_pix_valid=0, o_pix=0, o_frame_done=0, o_err=0.
REQ-033 Reset mid-frame SHALL discard in-flight samples; no output until the next i_sof.
REQ-034 o_err SHALL clear only on reset.

Structure
REQ-035 Shared package edge_pkg SHALL hold:
- the state enum;
- a pipeline-stage struct (valid, sum, border, last);
- default IMG_WIDTH/IMG_HEIGHT constants.
REQ-036 One sub-module, pixel_counter (col/row counters with wrap and last-pixel flag), SHALL be instantiated once; all other logic inline.

Verification
REQ-037 The bench SHALL run W=4, H=3 unless stated otherwise. It SHALL cover these directed scenarios:
- Pixel and border: i_sof, then 12 pairs gx=1000, gy=500, thresh off -> 12 outputs at +2 cycles; pixel (2,2) and (3,2) = 1500; all others 0; o_frame_done on the 12th output; state returns to IDLE.
- Saturation: gx=4000, gy=4000 at (2,2) -> o_pix=4095. gx=2^18-1, gy=2^18-1 -> 4095, no wrap.
- Threshold: i_thresh_en=1, i_threshold=1500; sum 1500 -> 4095; sum 1499 -> 0.
- Protocol error: i_gx_valid only, in ACTIVE -> no output, counters hold, o_err=1 until i_rst.
- i_sof mid-frame after 5 pairs -> o_err=1; next pair is (0,0); 12 further pairs produce o_frame_done.
- Reset: i_rst asserted with 2 samples in flight -> o_pix_valid=0 immediately; pairs before i_sof produce no output.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types for the edge-magnitude pipeline: FSM state, stage record, default geometry.
// No logic; no latency.
// No flow control of its own.
package edge_pkg;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    // Wide enough for the sum of two gradients of up to 32 bits each.
    localparam int STAGE_SUM_W = 33;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic [STAGE_SUM_W-1:0] sum;
        logic                   border;
        logic                   last;
    } stage_t;

endpackage

// File: rtl/pixel_counter.sv
// Column/row position tracker with wrap, start-of-frame restart and last-pixel flags.
// Position is combinational from registered counters; advance takes effect next cycle.
// No backpressure: advances on every accepted pair.
module pixel_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             sof,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last,
    output logic             held_last
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_nxt;

    // Start of frame overrides the stored position within the same cycle.
    assign col       = sof ? '0 : col_q;
    assign row       = sof ? '0 : row_q;
    assign last      = (col == COL_MAX) && (row == ROW_MAX);
    assign held_last = (col_q == COL_MAX) && (row_q == ROW_MAX);

    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (advance) begin
            if (col == COL_MAX) begin
                col_nxt = '0;
                row_nxt = (row == ROW_MAX) ? '0 : row + ROW_W'(1);
            end else begin
                col_nxt = col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_nxt;
            row_q <= row_nxt;
        end
    end

endmodule

// File: rtl/edge_magnitude.sv
// Edge magnitude |gx|+|gy| with saturation, optional binarisation and border blanking.
// Latency 2 cycles from accepted gradient pair to o_pix_valid; one output per pair.
// No backpressure: the pipeline advances every cycle; unpaired samples are dropped.
module edge_magnitude
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int GRAD_WIDTH = 18,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sof,
    input  logic                  i_gx_valid,
    input  logic [GRAD_WIDTH-1:0] i_gx,
    input  logic                  i_gy_valid,
    input  logic [GRAD_WIDTH-1:0] i_gy,
    input  logic                  i_thresh_en,
    input  logic [DATA_WIDTH-1:0] i_threshold,
    output logic                  o_pix_valid,
    output logic [DATA_WIDTH-1:0] o_pix,
    output logic                  o_frame_done,
    output logic                  o_err
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             active;
    logic             pair;
    logic             accept;
    logic             err_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last;
    logic             held_last;
    stage_t           s1;
    logic [DATA_WIDTH-1:0] sat;
    logic [DATA_WIDTH-1:0] pix_nxt;

    assign active = (state == ACTIVE);
    assign pair   = i_gx_valid & i_gy_valid;
    assign accept = pair & (active | i_sof);

    pixel_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_pixel_counter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .sof       (i_sof),
        .advance   (accept),
        .col       (col),
        .row       (row),
        .last      (last),
        .held_last (held_last)
    );

    always_comb begin
        state_nxt = state;
        if (i_sof) begin
            state_nxt = (accept && last) ? IDLE : ACTIVE;
        end else if (active && accept && last) begin
            state_nxt = IDLE;
        end
    end

    // Sticky: a lone gradient sample or a restart before the frame's end.
    assign err_nxt = o_err
                   | (active & (i_gx_valid ^ i_gy_valid))
                   | (active & i_sof & ~held_last);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            o_err <= 1'b0;
        end else begin
            state <= state_nxt;
            o_err <= err_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1 <= '0;
        end else begin
            s1.valid  <= accept;
            s1.sum    <= STAGE_SUM_W'(i_gx) + STAGE_SUM_W'(i_gy);
            s1.border <= (32'(col) < 32'd2) || (32'(row) < 32'd2);
            s1.last   <= accept & last;
        end
    end

    assign sat = (s1.sum > STAGE_SUM_W'(PIX_MAX)) ? PIX_MAX : s1.sum[DATA_WIDTH-1:0];

    always_comb begin
        pix_nxt = sat;
        if (s1.border) begin
            pix_nxt = '0;
        end else if (i_thresh_en) begin
            pix_nxt = (sat >= i_threshold) ? PIX_MAX : '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pix_valid  <= 1'b0;
            o_pix        <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_pix_valid  <= s1.valid;
            o_pix        <= s1.valid ? pix_nxt : '0;
            o_frame_done <= s1.valid & s1.last;
        end
    end

endmodule
